// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Single-issue front end for an external combinational ALU. Holds an
// 8-entry register file, reads operands when an instruction is accepted,
// presents them to the ALU for one cycle, captures the result and writes it
// back one cycle later. One instruction is in flight at a time, so the
// issue rate is one instruction every three cycles.
//
// Optional feature: define ALU_ISSUE_IMM_EN to let instr[3]=1 replace the
// second operand with the zero-extended 6-bit immediate {instr[6:4],instr[2:0]}.
// Without the macro instr[3:0] is ignored.
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        ALU_Sel,
    input  logic [DATA_W-1:0] ALU_Out,
    output logic              wb_valid,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Instruction field decode
    logic [2:0] op_s;
    logic [2:0] rd_s;
    logic [2:0] rs_s;
    logic [2:0] rt_s;
    logic       unused_instr_s;

    assign op_s = instr[15:13];
    assign rd_s = instr[12:10];
    assign rs_s = instr[9:7];
    assign rt_s = instr[6:4];
    // Spare bits are not consumed in every build configuration
    assign unused_instr_s = ^instr[3:0];

    // State registers and their next-state values
    state_e            state_q,   state_d;
    logic              ready_q,   ready_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [2:0]        sel_q,     sel_d;
    logic [2:0]        rd_q,      rd_d;
    logic              wbv_q,     wbv_d;
    logic [2:0]        wba_q,     wba_d;
    logic [DATA_W-1:0] wbd_q,     wbd_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic              accept_s;
    logic [DATA_W-1:0] operand_b_s;

    // An instruction is taken only while idle
    assign accept_s = (state_q == ST_IDLE) && instr_valid;

    // Second-operand source: register file, or the immediate when enabled
    always_comb begin
        operand_b_s = regs_q[rt_s];
`ifdef ALU_ISSUE_IMM_EN
        if (instr[3]) begin
            operand_b_s = {{(DATA_W-6){1'b0}}, instr[6:4], instr[2:0]};
        end else begin
            operand_b_s = regs_q[rt_s];
        end
`endif
    end

    // Next-state, operand, writeback and register-file update logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        wbv_d   = 1'b0;
        wba_d   = wba_q;
        wbd_d   = wbd_q;
        regs_d  = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Operands sampled now: a later writeback to rs/rt is not seen
                    a_d     = regs_q[rs_s];
                    b_d     = operand_b_s;
                    sel_d   = op_s;
                    rd_d    = rd_s;
                    state_d = ST_EXEC;
                end else if (dbg_we) begin
                    // Debug write only when no instruction is taken on this edge
                    regs_d[dbg_addr] = dbg_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                wbd_d   = ALU_Out;
                wba_d   = rd_q;
                wbv_d   = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                regs_d[rd_q] = wbd_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // r0 is hardwired to zero regardless of any write above
        regs_d[0] = {DATA_W{1'b0}};
        ready_d   = (state_d == ST_IDLE);
    end

    // State register with asynchronous reset discarding any in-flight work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            sel_q   <= 3'd0;
            rd_q    <= 3'd0;
            wbv_q   <= 1'b0;
            wba_q   <= 3'd0;
            wbd_q   <= {DATA_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wbv_q   <= wbv_d;
            wba_q   <= wba_d;
            wbd_q   <= wbd_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign instr_ready = ready_q;
    assign A           = a_q;
    assign B           = b_q;
    assign ALU_Sel     = sel_q;
    assign wb_valid    = wbv_q;
    assign wb_addr     = wba_q;
    assign wb_data     = wbd_q;
    assign dbg_rdata   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Directed bench for alu_issue with a behavioural ALU (ALU_Out = A + B).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_issue;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        ALU_Sel;
    logic [DATA_W-1:0] ALU_Out;
    logic              wb_valid;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              dbg_we;
    logic [2:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;

    int errors = 0;
    int checks = 0;

    alu_issue #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata)
    );

    // Behavioural ALU
    assign ALU_Out = A + B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [3:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dbg_write(input logic [2:0] addr, input logic [DATA_W-1:0] data);
        dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
        step();
        dbg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        dbg_we = 1'b0; dbg_addr = 3'd0; dbg_wdata = 16'h0000;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++;
        if ({A, B, ALU_Sel, wb_addr, wb_data} !== 54'd0) begin
            errors++; $display("FAIL reset_outputs: A=%h B=%h sel=%0d wa=%0d wd=%h expected all 0", A, B, ALU_Sel, wb_addr, wb_data);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            checks++;
            if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_rdata); end
        end
    endtask

    task automatic test_basic();
        dbg_write(3'd1, 16'h0AB0);
        dbg_write(3'd2, 16'h01AC);
        dbg_addr = 3'd1; #1;
        checks++;
        if (dbg_rdata !== 16'h0AB0) begin errors++; $display("FAIL dbg_r1: got %h expected 0AB0", dbg_rdata); end
        instr = enc(3'd1, 3'd3, 3'd1, 3'd2, 4'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++;
        if (A !== 16'h0AB0 || B !== 16'h01AC || ALU_Sel !== 3'd1) begin
            errors++; $display("FAIL basic_operands: A=%h B=%h sel=%0d expected 0AB0 01AC 1", A, B, ALU_Sel);
        end
        checks++;
        if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL basic_exec_ctrl: ready=%b wbv=%b expected 0 0", instr_ready, wb_valid);
        end
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'h0C5C) begin
            errors++; $display("FAIL basic_wb: wbv=%b wa=%0d wd=%h expected 1 3 0C5C", wb_valid, wb_addr, wb_data);
        end
        step();
        dbg_addr = 3'd3; #1;
        checks++;
        if (dbg_rdata !== 16'h0C5C) begin errors++; $display("FAIL basic_r3: got %h expected 0C5C", dbg_rdata); end
        checks++;
        if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || wb_data !== 16'h0C5C || wb_addr !== 3'd3) begin
            errors++; $display("FAIL basic_after_wb: wbv=%b ready=%b wd=%h wa=%0d expected 0 1 0C5C 3", wb_valid, instr_ready, wb_data, wb_addr);
        end
    endtask

    task automatic test_rd0();
        instr = enc(3'd0, 3'd0, 3'd1, 3'd2, 4'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd0 || wb_data !== 16'h0C5C) begin
            errors++; $display("FAIL rd0_wb: wbv=%b wa=%0d wd=%h expected 1 0 0C5C", wb_valid, wb_addr, wb_data);
        end
        step();
        dbg_addr = 3'd0; #1;
        checks++;
        if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL rd0_r0: got %h expected 0000", dbg_rdata); end
    endtask

    task automatic test_back_to_back();
        int wait_cycles;
        instr = enc(3'd2, 3'd4, 3'd1, 3'd1, 4'd0); instr_valid = 1'b1;
        step();
        // First accepted; offer the second immediately and count idle cycles
        instr = enc(3'd3, 3'd5, 3'd4, 3'd2, 4'd0);
        wait_cycles = 1;
        while (instr_ready !== 1'b1 && wait_cycles < 10) begin
            checks++;
            if (wb_valid === 1'b0 && wait_cycles == 2) begin
                errors++; $display("FAIL b2b_wb_pulse: got 0 expected 1 at cycle 2");
            end
            step();
            wait_cycles++;
        end
        checks++;
        if (wait_cycles != 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 3", wait_cycles); end
        step();
        instr_valid = 1'b0;
        checks++;
        if (A !== 16'h1560 || B !== 16'h01AC || ALU_Sel !== 3'd3) begin
            errors++; $display("FAIL b2b_operands: A=%h B=%h sel=%0d expected 1560 01AC 3", A, B, ALU_Sel);
        end
        step(); step();
        dbg_addr = 3'd5; #1;
        checks++;
        if (dbg_rdata !== 16'h170C) begin errors++; $display("FAIL b2b_r5: got %h expected 170C", dbg_rdata); end
    endtask

    task automatic test_dbg_exec();
        // Debug write on the accepting edge must be dropped
        instr = enc(3'd0, 3'd6, 3'd1, 3'd2, 4'd0); instr_valid = 1'b1;
        dbg_we = 1'b1; dbg_addr = 3'd7; dbg_wdata = 16'h1234;
        step();
        instr_valid = 1'b0;
        // Debug write during EXEC must be dropped
        dbg_addr = 3'd2; dbg_wdata = 16'hFFFF;
        step();
        dbg_we = 1'b0;
        step();
        dbg_addr = 3'd2; #1;
        checks++;
        if (dbg_rdata !== 16'h01AC) begin errors++; $display("FAIL dbg_exec_r2: got %h expected 01AC", dbg_rdata); end
        dbg_addr = 3'd7; #1;
        checks++;
        if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL dbg_accept_r7: got %h expected 0000", dbg_rdata); end
        dbg_addr = 3'd6; #1;
        checks++;
        if (dbg_rdata !== 16'h0C5C) begin errors++; $display("FAIL dbg_exec_r6: got %h expected 0C5C", dbg_rdata); end
    endtask

    task automatic test_imm();
        logic [DATA_W-1:0] exp_b;
        logic [DATA_W-1:0] exp_res;
`ifdef ALU_ISSUE_IMM_EN
        exp_b = 16'h002A; exp_res = 16'h0ADA;
`else
        exp_b = 16'h170C; exp_res = 16'h21BC;
`endif
        instr = enc(3'd0, 3'd7, 3'd1, 3'b101, 4'b1010); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++;
        if (B !== exp_b) begin errors++; $display("FAIL imm_B: got %h expected %h", B, exp_b); end
        step();
        checks++;
        if (wb_data !== exp_res) begin errors++; $display("FAIL imm_result: got %h expected %h", wb_data, exp_res); end
        step();
    endtask

    task automatic test_self_read();
        instr = enc(3'd0, 3'd1, 3'd1, 3'd1, 4'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++;
        if (A !== 16'h0AB0) begin errors++; $display("FAIL self_read_A: got %h expected 0AB0", A); end
        step(); step();
        dbg_addr = 3'd1; #1;
        checks++;
        if (dbg_rdata !== 16'h1560) begin errors++; $display("FAIL self_read_r1: got %h expected 1560", dbg_rdata); end
    endtask

    task automatic test_reset_mid();
        instr = enc(3'd1, 3'd3, 3'd1, 3'd2, 4'd0); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        rst = 1'b1; #1;
        checks++;
        if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || A !== 16'h0000) begin
            errors++; $display("FAIL rst_async: ready=%b wbv=%b A=%h expected 1 0 0000", instr_ready, wb_valid, A);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
                errors++; $display("FAIL rst_mid_cycle%0d: wbv=%b ready=%b expected 0 1", c, wb_valid, instr_ready);
            end
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            checks++;
            if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL rst_mid_reg%0d: got %h expected 0000", i, dbg_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd0();
        test_back_to_back();
        test_dbg_exec();
        test_imm();
        test_self_read();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
